misao_mem_arbiter: RTL and testbench

//  Shares the single byte-wide MISA-O memory port between the core's instruction fetch and its data

---
 rtl/misao_pkg.sv | 7 +
 rtl/misao_fetch_buf.sv | 43 ++++
 rtl/misao_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_misao_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/misao_pkg.sv
// misao_pkg: shared widths and FSM/owner encodings for the MISA-O memory arbiter
package misao_pkg;
    localparam int MISAO_ADDR_W = 15;
    localparam int MISAO_DATA_W = 8;
    typedef enum logic {ARB_IDLE, ARB_ACCESS} arb_state_e;
    typedef enum logic {OWN_IF, OWN_D} arb_owner_e;
endpackage

// File: rtl/misao_fetch_buf.sv
// misao_fetch_buf: one-entry fetch byte buffer with address-match hit
module misao_fetch_buf
    import misao_pkg::*;
#(
    parameter int ADDR_W = MISAO_ADDR_W,
    parameter int DATA_W = MISAO_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              inv,
    input  logic [ADDR_W-1:0] inv_addr,
    input  logic [ADDR_W-1:0] look_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = fill || (valid_q && !(inv && inv_addr == addr_q));
        addr_d  = fill ? fill_addr : addr_q;
        data_d  = fill ? fill_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign hit      = valid_q && look_addr == addr_q;
    assign hit_data = data_q;
endmodule

// File: rtl/misao_mem_arbiter.sv
// misao_mem_arbiter: fetch/data arbiter for the byte-wide MISA-O memory port (fetch buffer under MISAO_FETCH_BUF_EN)
module misao_mem_arbiter
    import misao_pkg::*;
#(
    parameter int ADDR_W      = MISAO_ADDR_W,
    parameter int DATA_W      = MISAO_DATA_W,
    parameter int WAIT_CYCLES = 1,
    parameter int STARVE_MAX  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_enable_read,
    output logic              mem_enable_write,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              busy
);
    localparam int WW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [WW-1:0] WAIT_INIT  = WW'(WAIT_CYCLES - 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    if (WAIT_CYCLES < 1 || STARVE_MAX < 1) begin : g_param_chk
        $error("misao_mem_arbiter: WAIT_CYCLES and STARVE_MAX must be >= 1");
    end

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              en_r_q, en_r_d, en_w_q, en_w_d, rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic              idle, done, if_fsm_req, if_win, if_fsm_gnt, d_wr;
    logic              buf_gnt;
    logic [DATA_W-1:0] buf_data;

    assign idle = state_q == ARB_IDLE;
    assign done = state_q == ARB_ACCESS && wait_q == '0;

`ifdef MISAO_FETCH_BUF_EN
    logic buf_hit;
    misao_fetch_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fetch_buf (
        .clk       (clk),
        .rst       (rst),
        .fill      (done && owner_q == OWN_IF),
        .fill_addr (addr_q),
        .fill_data (mem_data_in),
        .inv       (d_gnt && d_we),
        .inv_addr  (d_addr),
        .look_addr (if_addr),
        .hit       (buf_hit),
        .hit_data  (buf_data)
    );
    // A hit is held off only while an in-flight fetch is about to return on the same rvalid port
    assign buf_gnt = if_req && buf_hit && !(state_q == ARB_ACCESS && owner_q == OWN_IF);
`else
    assign buf_gnt  = 1'b0;
    assign buf_data = '0;
`endif

    assign if_fsm_req = if_req && !buf_gnt;
    assign if_win     = if_fsm_req && (!d_req || starve_q == STARVE_TOP);
    assign d_gnt      = idle && d_req && !if_win;
    assign if_fsm_gnt = idle && if_win;
    assign if_gnt     = if_fsm_gnt || buf_gnt;
    assign d_wr       = d_gnt && d_we;

    always_comb begin
        starve_d = buf_gnt ? starve_q
                 : (!if_fsm_req || if_fsm_gnt) ? '0
                 : (d_gnt && starve_q != STARVE_TOP) ? starve_q + 1'b1 : starve_q;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wait_d      = wait_q;
        en_r_d      = en_r_q;
        en_w_d      = en_w_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rvalid_d = buf_gnt;
        if_rdata_d  = buf_gnt ? buf_data : if_rdata_q;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        if (d_gnt || if_fsm_gnt) begin
            state_d = ARB_ACCESS;
            owner_d = d_gnt ? OWN_D : OWN_IF;
            wait_d  = WAIT_INIT;
            en_r_d  = !d_wr;
            en_w_d  = d_wr;
            rw_d    = !d_wr;
            addr_d  = d_gnt ? d_addr : if_addr;
            wdata_d = d_wr ? d_wdata : '0;
        end else if (done) begin
            state_d = ARB_IDLE;
            en_r_d  = 1'b0;
            en_w_d  = 1'b0;
            rw_d    = 1'b1;
            wdata_d = '0;
            if (owner_q == OWN_D) begin
                d_rvalid_d = 1'b1;
                d_rdata_d  = rw_q ? mem_data_in : '0;
            end else begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = mem_data_in;
            end
        end else if (!idle) begin
            wait_d = wait_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_IF;
            wait_q      <= '0;
            starve_q    <= '0;
            en_r_q      <= 1'b0;
            en_w_q      <= 1'b0;
            rw_q        <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wait_q      <= wait_d;
            starve_q    <= starve_d;
            en_r_q      <= en_r_d;
            en_w_q      <= en_w_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_rvalid        = if_rvalid_q;
    assign if_rdata         = if_rdata_q;
    assign d_rvalid         = d_rvalid_q;
    assign d_rdata          = d_rdata_q;
    assign mem_enable_read  = en_r_q;
    assign mem_enable_write = en_w_q;
    assign mem_rw           = rw_q;
    assign mem_addr         = addr_q;
    assign mem_data_out     = wdata_q;
    assign busy             = !idle;
endmodule

// File: tb/tb_misao_mem_arbiter.sv
// tb_misao_mem_arbiter: directed vectors, corner sequences and randomized model check of the arbiter
module tb_misao_mem_arbiter;
    localparam int AW = 15, DW = 8, W = 1, SM = 3;
`ifdef MISAO_FETCH_BUF_EN
    localparam bit FETCH_RND = 1'b0;
`else
    localparam bit FETCH_RND = 1'b1;
`endif

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic          if_req = 0, if_gnt, if_rvalid, d_req = 0, d_we = 0, d_gnt, d_rvalid;
    logic [AW-1:0] if_addr = '0, d_addr = '0, mem_addr;
    logic [DW-1:0] if_rdata, d_wdata = '0, d_rdata, mem_data_out, mem_data_in;
    logic          mem_enable_read, mem_enable_write, mem_rw, busy;

    misao_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_enable_read(mem_enable_read), .mem_enable_write(mem_enable_write), .mem_rw(mem_rw),
        .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .busy(busy)
    );

    logic          w3_if_req = 0, w3_if_gnt, w3_if_rvalid, w3_d_req = 0, w3_d_gnt, w3_d_rvalid;
    logic [AW-1:0] w3_d_addr = '0, w3_mem_addr;
    logic [DW-1:0] w3_if_rdata, w3_d_rdata, w3_mem_data_out;
    logic          w3_en_r, w3_en_w, w3_rw, w3_busy;

    misao_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(3), .STARVE_MAX(SM)) dut3 (
        .clk(clk), .rst(rst), .if_req(w3_if_req), .if_addr(15'h0001), .if_gnt(w3_if_gnt),
        .if_rvalid(w3_if_rvalid), .if_rdata(w3_if_rdata), .d_req(w3_d_req), .d_we(1'b0),
        .d_addr(w3_d_addr), .d_wdata(8'h00), .d_gnt(w3_d_gnt), .d_rvalid(w3_d_rvalid),
        .d_rdata(w3_d_rdata), .mem_enable_read(w3_en_r), .mem_enable_write(w3_en_w), .mem_rw(w3_rw),
        .mem_addr(w3_mem_addr), .mem_data_out(w3_mem_data_out), .mem_data_in(8'h5A), .busy(w3_busy)
    );

    logic [DW-1:0] mem_arr [0:63];
    assign mem_data_in = mem_arr[mem_addr[5:0]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= 8'(i * 7 + 1);
        end else if (mem_enable_write) begin
            mem_arr[mem_addr[5:0]] <= mem_data_out;
        end
    end

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic d_xact(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] exp);
        @(posedge clk); #1;
        d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
        @(negedge clk);
        chk("d_gnt", d_gnt, 1);
        chk("if_gnt_excl", if_gnt, 0);
        @(posedge clk); #1;
        d_req = 0;
        @(negedge clk);
        chk("mem_en_r", mem_enable_read, !we);
        chk("mem_en_w", mem_enable_write, we);
        chk("mem_rw", mem_rw, !we);
        chk("mem_addr", mem_addr, a);
        chk("mem_dout", mem_data_out, we ? wd : 8'h00);
        chk("d_rvalid_early", d_rvalid, 0);
        @(negedge clk);
        chk("d_rvalid", d_rvalid, 1);
        chk("d_rdata", d_rdata, exp);
        chk("if_rvalid_non_owner", if_rvalid, 0);
        chk("mem_en_idle", mem_enable_read | mem_enable_write, 0);
        chk("mem_dout_idle", mem_data_out, 0);
        @(negedge clk);
        chk("d_rvalid_pulse", d_rvalid, 0);
        chk("d_rdata_hold", d_rdata, exp);
    endtask

`ifdef MISAO_FETCH_BUF_EN
    task automatic if_fetch(input logic [AW-1:0] a, input logic [DW-1:0] exp, input logic miss);
        @(posedge clk); #1;
        if_req = 1; if_addr = a;
        @(negedge clk);
        chk("fb_gnt", if_gnt, 1);
        @(posedge clk); #1;
        if_req = 0;
        @(negedge clk);
        chk("fb_mem_strobe", mem_enable_read, miss);
        chk("fb_rvalid_hit", if_rvalid, !miss);
        if (miss) @(negedge clk);
        chk("fb_rvalid", if_rvalid, 1);
        chk("fb_rdata", if_rdata, exp);
    endtask
`endif

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic          own_d;
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    vec_t          vecs [6];
    exp_t          q [$];
    logic          got [8];
    logic          exp_order [8];
    logic [DW-1:0] ref_mem [64];

    initial begin
        int n, cyc, busy_until, starve;
        logic idle, exp_dg, exp_ig, exp_dv, exp_iv, cur_we, d_take, i_take;
        logic [DW-1:0] exp_dat;

        vecs[0] = '{1'b1, 15'h0020, 8'h3C, 8'h00};
        vecs[1] = '{1'b1, 15'h0010, 8'hA5, 8'h00};
        vecs[2] = '{1'b0, 15'h0010, 8'h00, 8'hA5};
        vecs[3] = '{1'b0, 15'h0020, 8'h00, 8'h3C};
        vecs[4] = '{1'b0, 15'h0005, 8'h00, 8'h24};
        vecs[5] = '{1'b0, 15'h003F, 8'h00, 8'hBA};
        exp_order = '{1, 1, 1, 0, 1, 1, 1, 0};

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_rvalid", {if_rvalid, d_rvalid}, 0);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);
        chk("rst_en", {mem_enable_read, mem_enable_write}, 0);
        chk("rst_mem_rw", mem_rw, 1);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_dout", mem_data_out, 0);
        chk("rst_busy", busy, 0);

        for (int i = 0; i < 6; i++) d_xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

        // contention: both requesters continuously asserted
        @(posedge clk); #1;
        if_req = 1; if_addr = 15'h0003; d_req = 1; d_we = 0; d_addr = 15'h0004;
        n = 0;
        for (int c = 0; c < 60 && n < 8; c++) begin
            @(negedge clk);
            chk("cont_excl", if_gnt && d_gnt, 0);
            if (d_gnt) begin
                got[n] = 1'b1; n++;
            end else if (if_gnt) begin
                got[n] = 1'b0; n++;
                if_addr = if_addr + 1'b1;
            end
        end
        @(posedge clk); #1;
        if_req = 0; d_req = 0;
        chk("cont_count", n, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("cont_order%0d", i), got[i], exp_order[i]);
        repeat (3) @(negedge clk);

        // reset in the middle of a read
        @(posedge clk); #1;
        d_req = 1; d_we = 0; d_addr = 15'h0007;
        @(negedge clk);
        chk("rstmid_gnt", d_gnt, 1);
        @(posedge clk); #1;
        d_req = 0; rst = 1;
        @(negedge clk);
        chk("rstmid_pre_en", mem_enable_read, 1);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rstmid_rvalid", d_rvalid, 0);
        chk("rstmid_en", {mem_enable_read, mem_enable_write}, 0);
        chk("rstmid_rw", mem_rw, 1);
        chk("rstmid_addr", mem_addr, 0);
        chk("rstmid_busy", busy, 0);
        @(negedge clk);
        chk("rstmid_rvalid2", d_rvalid, 0);
        d_xact(1'b0, 15'h0007, 8'h00, 8'h32);

        // WAIT_CYCLES=3 instance
        @(posedge clk); #1;
        w3_d_req = 1; w3_d_addr = 15'h0009;
        @(negedge clk);
        chk("w3_gnt", w3_d_gnt, 1);
        @(posedge clk); #1;
        w3_d_req = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("w3_en_r%0d", k), w3_en_r, 1);
            chk($sformatf("w3_addr%0d", k), w3_mem_addr, 15'h0009);
            chk($sformatf("w3_rvalid_early%0d", k), w3_d_rvalid, 0);
            chk($sformatf("w3_busy%0d", k), w3_busy, 1);
            if (k >= 2) chk($sformatf("w3_no_gnt%0d", k), w3_if_gnt, 0);
            if (k == 1) begin
                @(posedge clk); #1;
                w3_if_req = 1;
            end
        end
        @(negedge clk);
        chk("w3_rvalid", w3_d_rvalid, 1);
        chk("w3_rdata", w3_d_rdata, 8'h5A);
        chk("w3_en_off", w3_en_r, 0);
        chk("w3_if_gnt_rvcycle", w3_if_gnt, 1);
        @(posedge clk); #1;
        w3_if_req = 0;
        repeat (5) @(negedge clk);

`ifdef MISAO_FETCH_BUF_EN
        d_xact(1'b1, 15'h0005, 8'h7E, 8'h00);
        if_fetch(15'h0005, 8'h7E, 1'b1);
        if_fetch(15'h0005, 8'h7E, 1'b0);
        d_xact(1'b1, 15'h0005, 8'h11, 8'h00);
        if_fetch(15'h0005, 8'h11, 1'b1);
`endif

        // randomized traffic against the reference model
        @(posedge clk); #1;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 7 + 1);
        cyc = 0; busy_until = 0; starve = 0; cur_we = 0; d_take = 0; i_take = 0;
        q.delete();
        for (int it = 0; it < 3000; it++) begin
            @(posedge clk); #1;
            if (d_take) d_req = 0;
            if (i_take) if_req = 0;
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_req = 1;
                d_we = 1'($urandom_range(0, 1));
                d_addr = AW'($urandom_range(0, 63));
                d_wdata = DW'($urandom);
            end
            if (FETCH_RND && !if_req && $urandom_range(0, 1) == 1) begin
                if_req = 1;
                if_addr = AW'($urandom_range(0, 63));
            end
            @(negedge clk);
            cyc++;
            idle   = cyc >= busy_until;
            exp_dg = idle && d_req && !(if_req && starve == SM);
            exp_ig = idle && if_req && !exp_dg;
            chk("rnd_d_gnt", d_gnt, exp_dg);
            chk("rnd_if_gnt", if_gnt, exp_ig);
            chk("rnd_busy", busy, !idle);
            chk("rnd_en_r", mem_enable_read, !idle && !cur_we);
            chk("rnd_en_w", mem_enable_write, !idle && cur_we);
            exp_dv = 0; exp_iv = 0; exp_dat = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_dv  = q[0].own_d;
                exp_iv  = !q[0].own_d;
                exp_dat = q[0].data;
                void'(q.pop_front());
            end
            chk("rnd_d_rvalid", d_rvalid, exp_dv);
            chk("rnd_if_rvalid", if_rvalid, exp_iv);
            if (exp_dv) chk("rnd_d_rdata", d_rdata, exp_dat);
            if (exp_iv) chk("rnd_if_rdata", if_rdata, exp_dat);
            if (exp_dg) begin
                q.push_back('{1'b1, cyc + W + 1, d_we ? 8'h00 : ref_mem[d_addr[5:0]]});
                if (d_we) ref_mem[d_addr[5:0]] = d_wdata;
                cur_we = d_we;
                busy_until = cyc + W + 1;
            end
            if (exp_ig) begin
                q.push_back('{1'b0, cyc + W + 1, ref_mem[if_addr[5:0]]});
                cur_we = 0;
                busy_until = cyc + W + 1;
            end
            starve = (if_req && !exp_ig) ? starve + int'(exp_dg) : 0;
            d_take = exp_dg;
            i_take = exp_ig;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
